// File: rtl/sccb_config_master.sv
// SCCB (OV7670 two-wire) configuration master driven by custom instructions.
// The CPU issues single-register writes or reads; the bus is sequenced in
// quarter-bit steps produced by a down-counting tick generator.
module sccb_config_master #(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter int         clockFrequencyInHz  = 50000000,
    parameter int         sccbFrequencyInHz   = 100000,
    parameter logic [7:0] cameraWriteAddress  = 8'h42
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic [31:0] ciResult,
    output logic        ciDone,
    output logic        sccbClk,
    output logic        sccbDataOe,
    input  logic        sccbDataIn
);

    localparam int Q  = clockFrequencyInHz / (4 * sccbFrequencyInHz);
    localparam int CW = $clog2(Q);
    localparam logic [CW-1:0] RELOAD = CW'(Q - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_STOP, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic          phase_q, phase_d;
    logic          isRead_q;
    logic [7:0]    regAddr_q, wrData_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q, nack_q, rdValid_q;
    logic [7:0]    rdData_q, shift_q;
    logic          sync1_q, sync2_q;
    logic          sclk_q, oe_q;

    logic          accept, tick, finish, lastByte, readingByte, sampleNow;
    logic          sclk_d, sda_d, txBit;
    logic [7:0]    txByte;
    logic [1:0]    cmd;
    logic          unusedBits;

    // Byte to shift out for a given position: phase 1 of a read resends the ID
    // with the read flag and then releases the line for the slave's data byte.
    function automatic logic [7:0] byteFor(input logic rd, input logic ph, input logic [1:0] idx,
                                           input logic [7:0] ra, input logic [7:0] wd);
        if (idx == 2'd0)      return (rd && ph) ? (cameraWriteAddress | 8'h01) : cameraWriteAddress;
        else if (idx == 2'd1) return (rd && ph) ? 8'hFF : ra;
        else                  return wd;
    endfunction

    assign cmd         = ciValueA[1:0];
    assign ciDone      = ciStart & ciCke & (ciN == customInstructionId);
    assign accept      = ciDone & ~cmd[1] & ~busy_q;
    assign tick        = busy_q & (cnt_q == '0);
    assign lastByte    = isRead_q ? (byte_q == 2'd1) : (byte_q == 2'd2);
    assign readingByte = isRead_q & phase_q & (byte_q == 2'd1);
    assign sampleNow   = tick & (state_q == S_BITS) & (qtr_q == 2'd2);
    assign sccbClk     = sclk_q;
    assign sccbDataOe  = oe_q;
    assign unusedBits  = ^{ciValueA[31:2], ciValueB[31:16]};

    // CI result mux; zero whenever this block is not addressed.
    always_comb begin
        ciResult = 32'd0;
        if (ciDone) begin
            case (cmd)
                2'd0, 2'd1: ciResult = {31'd0, ~busy_q};
                2'd2:       ciResult = {16'd0, rdData_q, 5'd0, rdValid_q, nack_q, busy_q};
                default:    ciResult = 32'd0;
            endcase
        end
    end

    // Bus position sequencer: advances one quarter per tick through the segments.
    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        phase_d = phase_q;
        finish  = 1'b0;
        if (accept) begin
            state_d = S_START;
            qtr_d   = 2'd0;
            bit_d   = 4'd0;
            byte_d  = 2'd0;
            phase_d = 1'b0;
        end else if (tick) begin
            case (state_q)
                S_START: begin
                    if (qtr_q == 2'd1) begin
                        state_d = S_BITS;
                        qtr_d   = 2'd0;
                        bit_d   = 4'd0;
                        byte_d  = 2'd0;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
                S_BITS: begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (bit_q == 4'd8) begin
                            bit_d = 4'd0;
                            if (lastByte) state_d = S_STOP;
                            else          byte_d  = byte_q + 2'd1;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (qtr_q == 2'd2) begin
                        qtr_d = 2'd0;
                        if (isRead_q && !phase_q) begin
                            state_d = S_GAP;
                            phase_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            finish  = 1'b1;
                        end
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
                S_GAP: begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) state_d = S_START;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Pin levels for the upcoming bus position, registered below.
    always_comb begin
        txByte = byteFor(isRead_q, phase_d, byte_d, regAddr_q, wrData_q);
        txBit  = (bit_d == 4'd8) ? 1'b1 : txByte[~bit_d[2:0]];
        sclk_d = 1'b1;
        sda_d  = 1'b1;
        case (state_d)
            S_START: sda_d = (qtr_d == 2'd0);
            S_BITS: begin
                sclk_d = qtr_d[1];
                sda_d  = txBit;
            end
            S_STOP: begin
                sclk_d = (qtr_d != 2'd0);
                sda_d  = (qtr_d == 2'd2);
            end
            default: ;
        endcase
    end

    // Two-flop synchroniser for the SIOD pin.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sccbDataIn;
            sync2_q <= sync1_q;
        end
    end

    // Command acceptance, tick counter, FSM state, status and registered pins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            qtr_q     <= 2'd0;
            bit_q     <= 4'd0;
            byte_q    <= 2'd0;
            phase_q   <= 1'b0;
            isRead_q  <= 1'b0;
            regAddr_q <= 8'd0;
            wrData_q  <= 8'd0;
            cnt_q     <= RELOAD;
            busy_q    <= 1'b0;
            nack_q    <= 1'b0;
            rdValid_q <= 1'b0;
            rdData_q  <= 8'd0;
            shift_q   <= 8'd0;
            sclk_q    <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            phase_q <= phase_d;
            sclk_q  <= sclk_d;
            oe_q    <= ~sda_d;
            if (accept || tick) cnt_q <= RELOAD;
            else if (busy_q)    cnt_q <= cnt_q - CW'(1);
            if (accept) begin
                busy_q   <= 1'b1;
                nack_q   <= 1'b0;
                isRead_q <= cmd[0];
                if (cmd[0]) begin
                    regAddr_q <= ciValueB[7:0];
                    rdValid_q <= 1'b0;
                end else begin
                    regAddr_q <= ciValueB[15:8];
                    wrData_q  <= ciValueB[7:0];
                end
            end else begin
                if (sampleNow && bit_q != 4'd8 && readingByte) shift_q <= {shift_q[6:0], sync2_q};
                if (sampleNow && bit_q == 4'd8 && !readingByte && sync2_q) nack_q <= 1'b1;
                if (finish) begin
                    busy_q <= 1'b0;
                    if (isRead_q) begin
                        rdData_q  <= shift_q;
                        rdValid_q <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sccb_config_master.sv
// Directed bench for sccb_config_master with a behavioural SCCB slave that
// acknowledges, returns read data and logs every byte and stop it observes.
module tb_sccb_config_master;

    localparam logic [7:0] ID = 8'd0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ciStart = 1'b0;
    logic        ciCke = 1'b0;
    logic [7:0]  ciN = 8'd0;
    logic [31:0] ciValueA = 32'd0;
    logic [31:0] ciValueB = 32'd0;
    logic [31:0] ciResult;
    logic        ciDone;
    logic        sccbClk;
    logic        sccbDataOe;
    logic        sccbDataIn;
    logic        slaveLow = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          smpCyc = 0;
    int          accCyc = 0;
    int          nackByte = -1;
    logic [7:0]  rdByte = 8'h76;
    int          expQ[$];
    int          capQ[$];

    sccb_config_master #(
        .customInstructionId(ID),
        .clockFrequencyInHz(4000000),
        .sccbFrequencyInHz(100000),
        .cameraWriteAddress(8'h42)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ciStart(ciStart),
        .ciCke(ciCke),
        .ciN(ciN),
        .ciValueA(ciValueA),
        .ciValueB(ciValueB),
        .ciResult(ciResult),
        .ciDone(ciDone),
        .sccbClk(sccbClk),
        .sccbDataOe(sccbDataOe),
        .sccbDataIn(sccbDataIn)
    );

    assign sccbDataIn = ~(sccbDataOe | slaveLow);

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CI transaction: drive on the falling edge, sample combinational results.
    task automatic ciOp(input logic [7:0] n, input logic [1:0] cmd, input logic [31:0] b,
                        output logic done, output logic [31:0] res);
        @(negedge clock);
        ciStart  = 1'b1;
        ciCke    = 1'b1;
        ciN      = n;
        ciValueA = {30'd0, cmd};
        ciValueB = b;
        #1;
        done   = ciDone;
        res    = ciResult;
        smpCyc = cyc;
        @(posedge clock);
        #1;
        ciStart = 1'b0;
        ciCke   = 1'b0;
    endtask

    // Poll STATUS every cycle until busy drops; k is clocks since accept.
    task automatic waitIdle(input int limit, output int k, output logic [31:0] st, output logic [31:0] prev);
        logic        d;
        logic [31:0] r;
        k    = -1;
        st   = 32'hFFFF_FFFF;
        prev = 32'd0;
        for (int i = 0; i < limit; i++) begin
            ciOp(ID, 2'd2, 32'd0, d, r);
            if (!r[0]) begin
                st = r;
                k  = smpCyc - accCyc;
                return;
            end
            prev = r;
        end
    endtask

    task automatic cmpBus(input string tag);
        int a;
        int e;
        chk({tag, "_count"}, capQ.size(), expQ.size());
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            a = (capQ.size() > 0) ? capQ.pop_front() : -1;
            chk(tag, a, e);
        end
        capQ.delete();
    endtask

    // Behavioural slave: detects start/stop, shifts bits on SIOC rise, drives ACK/data after SIOC fall.
    initial begin
        logic       pScl, pSda, scl, sda, active, rw;
        int         bitn, byten;
        logic [7:0] sh;
        pScl = 1'b1; pSda = 1'b1; active = 1'b0; rw = 1'b0; bitn = 0; byten = 0; sh = 8'd0;
        forever begin
            @(negedge clock);
            scl = sccbClk;
            sda = sccbDataIn;
            if (reset) begin
                slaveLow = 1'b0;
                active   = 1'b0;
            end else if (pScl && scl && pSda && !sda) begin
                active = 1'b1; bitn = 0; byten = 0; sh = 8'd0; rw = 1'b0;
            end else if (pScl && scl && !pSda && sda) begin
                if (active) capQ.push_back(256);
                active   = 1'b0;
                slaveLow = 1'b0;
            end else if (active && !pScl && scl) begin
                if (bitn < 8) begin
                    sh = {sh[6:0], sda};
                    bitn++;
                end else begin
                    if (byten == 0) rw = sh[0];
                    capQ.push_back(int'(sh));
                    bitn = 0;
                    byten++;
                end
            end else if (active && pScl && !scl) begin
                if (bitn == 8 && !(rw && byten >= 1)) slaveLow = (byten != nackByte);
                else if (rw && byten == 1 && bitn < 8) slaveLow = ~rdByte[7 - bitn];
                else slaveLow = 1'b0;
            end
            pScl = scl;
            pSda = sda;
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout CHECKS %0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic        d;
        logic [31:0] r, st, prev;
        int          k;

        // Reset levels
        repeat (3) @(negedge clock);
        chk("rst_sclk", {31'd0, sccbClk}, 32'd1);
        chk("rst_oe", {31'd0, sccbDataOe}, 32'd0);
        reset = 1'b0;
        ciOp(ID, 2'd2, 32'd0, d, r);
        chk("rst_status_done", {31'd0, d}, 32'd1);
        chk("rst_status", r, 32'd0);

        // Non-addressed CI starts nothing
        ciOp(8'd5, 2'd0, 32'h0000_1280, d, r);
        chk("na_done", {31'd0, d}, 32'd0);
        chk("na_result", r, 32'd0);
        repeat (50) @(negedge clock);
        chk("na_sclk", {31'd0, sccbClk}, 32'd1);
        chk("na_oe", {31'd0, sccbDataOe}, 32'd0);
        chk("na_bus", capQ.size(), 32'd0);
        ciOp(ID, 2'd2, 32'd0, d, r);
        chk("na_status", r, 32'd0);
        ciOp(ID, 2'd3, 32'hFFFF_FFFF, d, r);
        chk("cmd3_result", r, 32'd0);

        // WRITE 0x12 <= 0x80, with a rejected WRITE mid-transaction
        ciOp(ID, 2'd0, 32'h0000_1280, d, r);
        accCyc = smpCyc + 1;
        expQ.push_back(32'h42); expQ.push_back(32'h12); expQ.push_back(32'h80); expQ.push_back(256);
        chk("wr_accept", r, 32'd1);
        repeat (200) @(negedge clock);
        ciOp(ID, 2'd0, 32'h0000_FFFF, d, r);
        chk("wr_busy_reject", r, 32'd0);
        ciOp(ID, 2'd1, 32'h0000_00FF, d, r);
        chk("rd_busy_reject", r, 32'd0);
        waitIdle(2000, k, st, prev);
        chk("wr_time", {31'd0, (k >= 1129 && k <= 1131)}, 32'd1);
        chk("wr_status", st, 32'd0);
        cmpBus("wr_bus");

        // NACK on the ID byte
        nackByte = 0;
        ciOp(ID, 2'd0, 32'h0000_3344, d, r);
        accCyc = smpCyc + 1;
        expQ.push_back(32'h42); expQ.push_back(32'h33); expQ.push_back(32'h44); expQ.push_back(256);
        chk("nk_accept", r, 32'd1);
        waitIdle(2000, k, st, prev);
        chk("nk_time", {31'd0, (k >= 1129 && k <= 1131)}, 32'd1);
        chk("nk_status", st, 32'h0000_0002);
        cmpBus("nk_bus");
        nackByte = -1;

        // READ reg 0x0A, slave returns 0x76; accept clears the sticky nack
        ciOp(ID, 2'd1, 32'h0000_000A, d, r);
        accCyc = smpCyc + 1;
        expQ.push_back(32'h42); expQ.push_back(32'h0A); expQ.push_back(256);
        expQ.push_back(32'h43); expQ.push_back(32'h76); expQ.push_back(256);
        chk("rd_accept", r, 32'd1);
        ciOp(ID, 2'd2, 32'd0, d, r);
        chk("rd_status_busy", r, 32'h0000_0001);
        waitIdle(2500, k, st, prev);
        chk("rd_time", {31'd0, (k >= 1579 && k <= 1581)}, 32'd1);
        chk("rd_prev_status", prev, 32'h0000_0001);
        chk("rd_status", st, 32'h0000_7604);
        cmpBus("rd_bus");

        // Reset in the middle of a write
        ciOp(ID, 2'd0, 32'h0000_1111, d, r);
        chk("mr_accept", r, 32'd1);
        for (int i = 0; i < 500 && sccbClk; i++) @(negedge clock);
        chk("mr_sclk_low", {31'd0, sccbClk}, 32'd0);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_sclk", {31'd0, sccbClk}, 32'd1);
        chk("mr_oe", {31'd0, sccbDataOe}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        ciOp(ID, 2'd2, 32'd0, d, r);
        chk("mr_status", r, 32'd0);
        repeat (100) @(negedge clock);
        chk("mr_idle_sclk", {31'd0, sccbClk}, 32'd1);
        capQ.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
